// File: rtl/fir_window_gen.sv
// Horizontal window generator: turns a stream of vertical tap columns into
// TAP_NUMS x TAP_NUMS windows, replicating edge columns at both line ends.
module fir_window_gen #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned TAP_NUMS   = 3,
   parameter int unsigned LINE_CNT   = 12
) (
   input  logic                                     clk,
   input  logic                                     rst_n,
   input  logic                                     col_en_i,
   input  logic [TAP_NUMS*DATA_WIDTH-1:0]           col_data_i,
   input  logic [LINE_CNT-1:0]                      h_size_i,
   output logic                                     win_en_o,
   output logic [TAP_NUMS*TAP_NUMS*DATA_WIDTH-1:0]  win_data_o,
   output logic                                     win_first_o,
   output logic                                     win_last_o,
   output logic                                     busy_o,
   output logic                                     ovf_o
);

   localparam int unsigned HALF  = (TAP_NUMS - 1) / 2;
   localparam int unsigned COL_W = TAP_NUMS * DATA_WIDTH;
   localparam int unsigned FC_W  = $clog2(HALF + 1);

   typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

   state_t                              state, state_nxt;
   logic [TAP_NUMS-1:0][COL_W-1:0]      sr, sr_nxt, shifted;
   logic [LINE_CNT-1:0]                 col_cnt, col_cnt_nxt;
   logic [LINE_CNT-1:0]                 h_size_r, h_size_nxt;
   logic [FC_W-1:0]                     flush_cnt, flush_nxt;
   logic                                ovf_nxt;
   logic                                emit, first, last;

   // Shift register advanced by one column; in FLUSH the newest column is replicated
   always_comb begin
      for (int c = 0; c < int'(TAP_NUMS) - 1; c++) begin
         shifted[c] = sr[c+1];
      end
      shifted[TAP_NUMS-1] = (state == FLUSH) ? sr[TAP_NUMS-1] : col_data_i;
   end

   // Next-state and datapath control
   always_comb begin
      state_nxt   = state;
      sr_nxt      = sr;
      col_cnt_nxt = col_cnt;
      h_size_nxt  = h_size_r;
      flush_nxt   = flush_cnt;
      ovf_nxt     = ovf_o;
      emit        = 1'b0;
      first       = 1'b0;
      last        = 1'b0;

      unique case (state)
         IDLE: begin
            if (col_en_i) begin
               sr_nxt      = {TAP_NUMS{col_data_i}};
               h_size_nxt  = h_size_i;
               col_cnt_nxt = LINE_CNT'(1);
               // A single-column line is already complete; go straight to flushing
               if (h_size_i <= LINE_CNT'(1)) begin
                  state_nxt = FLUSH;
                  flush_nxt = FC_W'(HALF);
               end else begin
                  state_nxt = RUN;
               end
            end
         end
         RUN: begin
            if (col_en_i) begin
               sr_nxt      = shifted;
               col_cnt_nxt = col_cnt + LINE_CNT'(1);
               if (col_cnt >= LINE_CNT'(HALF)) begin
                  emit  = 1'b1;
                  first = (col_cnt == LINE_CNT'(HALF));
               end
               if (col_cnt >= h_size_r - LINE_CNT'(1)) begin
                  state_nxt = FLUSH;
                  flush_nxt = FC_W'(HALF);
               end
            end
         end
         FLUSH: begin
            sr_nxt    = shifted;
            emit      = 1'b1;
            flush_nxt = flush_cnt - FC_W'(1);
            if (col_en_i) begin
               ovf_nxt = 1'b1;
            end
            if (flush_cnt <= FC_W'(1)) begin
               last        = 1'b1;
               state_nxt   = IDLE;
               col_cnt_nxt = '0;
            end
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, storage and registered outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         sr          <= '0;
         col_cnt     <= '0;
         h_size_r    <= '0;
         flush_cnt   <= '0;
         win_en_o    <= 1'b0;
         win_data_o  <= '0;
         win_first_o <= 1'b0;
         win_last_o  <= 1'b0;
         busy_o      <= 1'b0;
         ovf_o       <= 1'b0;
      end else begin
         state       <= state_nxt;
         sr          <= sr_nxt;
         col_cnt     <= col_cnt_nxt;
         h_size_r    <= h_size_nxt;
         flush_cnt   <= flush_nxt;
         win_en_o    <= emit;
         if (emit) begin
            win_data_o <= sr_nxt;
         end
         win_first_o <= first;
         win_last_o  <= last;
         busy_o      <= (state_nxt != IDLE);
         ovf_o       <= ovf_nxt;
      end
   end

endmodule

// File: tb/tb_fir_window_gen.sv
// Self-checking bench for fir_window_gen: random columns scored against a
// clamped-index window model, for TAP_NUMS=3 and TAP_NUMS=5 instances.
module tb_fir_window_gen;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic         col_en3, win_en3, win_first3, win_last3, busy3, ovf3;
   logic [23:0]  col_data3;
   logic [11:0]  h_size3;
   logic [71:0]  win_data3;
   logic         col_en5, win_en5, win_first5, win_last5, busy5, ovf5;
   logic [39:0]  col_data5;
   logic [11:0]  h_size5;
   logic [199:0] win_data5;

   fir_window_gen #(.DATA_WIDTH(8), .TAP_NUMS(3), .LINE_CNT(12)) dut3 (
      .clk(clk), .rst_n(rst_n), .col_en_i(col_en3), .col_data_i(col_data3),
      .h_size_i(h_size3), .win_en_o(win_en3), .win_data_o(win_data3),
      .win_first_o(win_first3), .win_last_o(win_last3), .busy_o(busy3), .ovf_o(ovf3));

   fir_window_gen #(.DATA_WIDTH(8), .TAP_NUMS(5), .LINE_CNT(12)) dut5 (
      .clk(clk), .rst_n(rst_n), .col_en_i(col_en5), .col_data_i(col_data5),
      .h_size_i(h_size5), .win_en_o(win_en5), .win_data_o(win_data5),
      .win_first_o(win_first5), .win_last_o(win_last5), .busy_o(busy5), .ovf_o(ovf5));

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [23:0] cols3 [0:31];
   int          colcyc3 [0:31];
   logic [39:0] cols5 [0:7];
   int          colcyc5 [0:7];

   logic [71:0]  q3_data [$];
   bit           q3_first [$], q3_last [$];
   int           q3_cyc [$];
   logic [199:0] q5_data [$];
   bit           q5_first [$], q5_last [$];
   int           q5_cyc [$];

   // Capture every emitted window with its flags and cycle stamp
   always @(negedge clk) begin
      if (win_en3) begin
         q3_data.push_back(win_data3); q3_first.push_back(win_first3);
         q3_last.push_back(win_last3); q3_cyc.push_back(cyc);
      end
      if (win_en5) begin
         q5_data.push_back(win_data5); q5_first.push_back(win_first5);
         q5_last.push_back(win_last5); q5_cyc.push_back(cyc);
      end
   end

   // Window k = columns k-HALF..k+HALF, indices clamped into 0..w-1
   function automatic logic [71:0] exp_win3(input int base, input int w, input int k);
      logic [71:0] r;
      int idx;
      r = '0;
      for (int c = 0; c < 3; c++) begin
         idx = k - 1 + c;
         if (idx < 0) idx = 0;
         if (idx > w - 1) idx = w - 1;
         r[c*24 +: 24] = cols3[base+idx];
      end
      return r;
   endfunction

   function automatic logic [199:0] exp_win5(input int w, input int k);
      logic [199:0] r;
      int idx;
      r = '0;
      for (int c = 0; c < 5; c++) begin
         idx = k - 2 + c;
         if (idx < 0) idx = 0;
         if (idx > w - 1) idx = w - 1;
         r[c*40 +: 40] = cols5[idx];
      end
      return r;
   endfunction

   // A window is complete when column k+HALF arrives, or on the matching flush cycle
   function automatic int exp_cyc3(input int base, input int w, input int k);
      int j;
      j = k + 1;
      if (j <= w - 1) return colcyc3[base+j];
      return colcyc3[base+w-1] + (j - (w - 1));
   endfunction

   function automatic int exp_cyc5(input int w, input int k);
      int j;
      j = k + 2;
      if (j <= w - 1) return colcyc5[j];
      return colcyc5[w-1] + (j - (w - 1));
   endfunction

   task automatic fill3(input int base, input int n);
      for (int i = 0; i < n; i++) cols3[base+i] = 24'($urandom);
   endtask

   task automatic clear3();
      q3_data.delete(); q3_first.delete(); q3_last.delete(); q3_cyc.delete();
   endtask

   task automatic drive_line3(input int base, input int w, input int ncols,
                              input int gmin, input int gmax);
      for (int j = 0; j < ncols; j++) begin
         col_en3   = 1'b1;
         col_data3 = cols3[base+j];
         h_size3   = 12'(w);
         @(posedge clk); #1;
         colcyc3[base+j] = cyc;
         col_en3 = 1'b0;
         repeat ($urandom_range(gmax, gmin)) begin @(posedge clk); #1; end
      end
   endtask

   task automatic wait_idle3(input string name);
      int n;
      n = 0;
      while (busy3 && n < 64) begin @(posedge clk); #1; n++; end
      checks++;
      if (busy3) begin
         errors++;
         $display("FAIL %s idle_timeout busy=%0b required=0", name, busy3);
      end
      repeat (2) begin @(posedge clk); #1; end
   endtask

   task automatic test_reset();
      #1;
      checks++;
      if ({win_en3, win_first3, win_last3, busy3, ovf3, win_data3} !== '0) begin
         errors++;
         $display("FAIL reset3 got en=%0b f=%0b l=%0b busy=%0b ovf=%0b data=%h required all 0",
                  win_en3, win_first3, win_last3, busy3, ovf3, win_data3);
      end
      checks++;
      if ({win_en5, win_first5, win_last5, busy5, ovf5, win_data5} !== '0) begin
         errors++;
         $display("FAIL reset5 got en=%0b busy=%0b ovf=%0b data=%h required all 0",
                  win_en5, busy5, ovf5, win_data5);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_line3(input string name, input int w, input int gmin, input int gmax);
      bit ef, el;
      int ec;
      clear3();
      fill3(0, w);
      drive_line3(0, w, w, gmin, gmax);
      wait_idle3(name);
      checks++;
      if (q3_data.size() != w) begin
         errors++;
         $display("FAIL %s win_count got=%0d required=%0d", name, q3_data.size(), w);
      end
      for (int k = 0; k < w && k < q3_data.size(); k++) begin
         checks++;
         if (q3_data[k] !== exp_win3(0, w, k)) begin
            errors++;
            $display("FAIL %s win%0d_data got=%h required=%h", name, k, q3_data[k], exp_win3(0, w, k));
         end
         ef = (k == 0); el = (k == w - 1); ec = exp_cyc3(0, w, k);
         checks++;
         if (q3_first[k] !== ef || q3_last[k] !== el || q3_cyc[k] != ec) begin
            errors++;
            $display("FAIL %s win%0d_ctl got first=%0b last=%0b cyc=%0d required first=%0b last=%0b cyc=%0d",
                     name, k, q3_first[k], q3_last[k], q3_cyc[k], ef, el, ec);
         end
      end
      checks++;
      if (ovf3 !== 1'b0) begin
         errors++;
         $display("FAIL %s ovf got=%0b required=0", name, ovf3);
      end
   endtask

   task automatic test_tap5();
      int n;
      bit ef, el;
      q5_data.delete(); q5_first.delete(); q5_last.delete(); q5_cyc.delete();
      for (int j = 0; j < 3; j++) cols5[j] = {8'($urandom), 32'($urandom)};
      for (int j = 0; j < 3; j++) begin
         col_en5 = 1'b1; col_data5 = cols5[j]; h_size5 = 12'd3;
         @(posedge clk); #1;
         colcyc5[j] = cyc;
         col_en5 = 1'b0;
      end
      n = 0;
      while (busy5 && n < 64) begin @(posedge clk); #1; n++; end
      repeat (2) begin @(posedge clk); #1; end
      checks++;
      if (q5_data.size() != 3) begin
         errors++;
         $display("FAIL tap5 win_count got=%0d required=3", q5_data.size());
      end
      for (int k = 0; k < 3 && k < q5_data.size(); k++) begin
         checks++;
         if (q5_data[k] !== exp_win5(3, k)) begin
            errors++;
            $display("FAIL tap5 win%0d_data got=%h required=%h", k, q5_data[k], exp_win5(3, k));
         end
         ef = (k == 0); el = (k == 2);
         checks++;
         if (q5_first[k] !== ef || q5_last[k] !== el || q5_cyc[k] != exp_cyc5(3, k)) begin
            errors++;
            $display("FAIL tap5 win%0d_ctl got first=%0b last=%0b cyc=%0d required first=%0b last=%0b cyc=%0d",
                     k, q5_first[k], q5_last[k], q5_cyc[k], ef, el, exp_cyc5(3, k));
         end
      end
   endtask

   task automatic test_back_to_back();
      int base, kk;
      bit ef, el;
      clear3();
      fill3(0, 8);
      drive_line3(0, 4, 4, 0, 0);
      @(posedge clk); #1;
      drive_line3(4, 4, 4, 0, 0);
      wait_idle3("b2b");
      checks++;
      if (q3_data.size() != 8) begin
         errors++;
         $display("FAIL b2b win_count got=%0d required=8", q3_data.size());
      end
      for (int k = 0; k < 8 && k < q3_data.size(); k++) begin
         base = (k / 4) * 4; kk = k % 4;
         checks++;
         if (q3_data[k] !== exp_win3(base, 4, kk)) begin
            errors++;
            $display("FAIL b2b win%0d_data got=%h required=%h", k, q3_data[k], exp_win3(base, 4, kk));
         end
         ef = (kk == 0); el = (kk == 3);
         checks++;
         if (q3_first[k] !== ef || q3_last[k] !== el || q3_cyc[k] != exp_cyc3(base, 4, kk)) begin
            errors++;
            $display("FAIL b2b win%0d_ctl got first=%0b last=%0b cyc=%0d required first=%0b last=%0b cyc=%0d",
                     k, q3_first[k], q3_last[k], q3_cyc[k], ef, el, exp_cyc3(base, 4, kk));
         end
      end
      checks++;
      if (ovf3 !== 1'b0) begin
         errors++;
         $display("FAIL b2b ovf got=%0b required=0", ovf3);
      end
   endtask

   task automatic test_overflow();
      clear3();
      fill3(0, 8);
      drive_line3(0, 4, 4, 0, 0);
      col_en3 = 1'b1; col_data3 = 24'($urandom); h_size3 = 12'd4;
      @(posedge clk); #1;
      col_en3 = 1'b0;
      checks++;
      if (ovf3 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_set got=%0b required=1", ovf3);
      end
      wait_idle3("ovf_line1");
      checks++;
      if (q3_data.size() != 4) begin
         errors++;
         $display("FAIL ovf_line1 win_count got=%0d required=4", q3_data.size());
      end
      checks++;
      if (q3_data.size() == 4 && (q3_data[3] !== exp_win3(0, 4, 3) || q3_last[3] !== 1'b1)) begin
         errors++;
         $display("FAIL ovf_line1 last_win got=%h last=%0b required=%h last=1",
                  q3_data[3], q3_last[3], exp_win3(0, 4, 3));
      end
      clear3();
      drive_line3(4, 4, 4, 0, 0);
      wait_idle3("ovf_line2");
      checks++;
      if (q3_data.size() != 4) begin
         errors++;
         $display("FAIL ovf_line2 win_count got=%0d required=4", q3_data.size());
      end
      for (int k = 0; k < 4 && k < q3_data.size(); k++) begin
         checks++;
         if (q3_data[k] !== exp_win3(4, 4, k) || q3_first[k] !== (k == 0) || q3_last[k] !== (k == 3)) begin
            errors++;
            $display("FAIL ovf_line2 win%0d got=%h f=%0b l=%0b required=%h f=%0b l=%0b",
                     k, q3_data[k], q3_first[k], q3_last[k], exp_win3(4, 4, k), k == 0, k == 3);
         end
      end
      checks++;
      if (ovf3 !== 1'b1) begin
         errors++;
         $display("FAIL ovf_sticky got=%0b required=1", ovf3);
      end
   endtask

   task automatic test_mid_reset();
      clear3();
      fill3(0, 6);
      drive_line3(0, 6, 3, 0, 0);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({win_en3, win_first3, win_last3, busy3, ovf3} !== 5'b0) begin
         errors++;
         $display("FAIL midrst_ctl got en=%0b f=%0b l=%0b busy=%0b ovf=%0b required all 0",
                  win_en3, win_first3, win_last3, busy3, ovf3);
      end
      checks++;
      if (win_data3 !== 72'h0) begin
         errors++;
         $display("FAIL midrst_data got=%h required=0", win_data3);
      end
      @(posedge clk); #1;
      rst_n = 1'b1;
      @(posedge clk); #1;
      clear3();
      fill3(8, 4);
      drive_line3(8, 4, 4, 0, 0);
      wait_idle3("midrst_line");
      checks++;
      if (q3_data.size() != 4) begin
         errors++;
         $display("FAIL midrst_line win_count got=%0d required=4", q3_data.size());
      end
      for (int k = 0; k < 4 && k < q3_data.size(); k++) begin
         checks++;
         if (q3_data[k] !== exp_win3(8, 4, k) || q3_first[k] !== (k == 0) || q3_last[k] !== (k == 3)) begin
            errors++;
            $display("FAIL midrst_line win%0d got=%h f=%0b l=%0b required=%h f=%0b l=%0b",
                     k, q3_data[k], q3_first[k], q3_last[k], exp_win3(8, 4, k), k == 0, k == 3);
         end
      end
   endtask

   initial begin
      col_en3 = 1'b0; col_data3 = '0; h_size3 = '0;
      col_en5 = 1'b0; col_data5 = '0; h_size5 = '0;
      repeat (3) @(posedge clk);
      test_reset();
      test_line3("basic_w4", 4, 0, 0);
      test_tap5();
      test_line3("gapped_w6", 6, 1, 1);
      test_line3("min_w2", 2, 0, 0);
      for (int i = 0; i < 3; i++) test_line3("random", int'($urandom_range(12, 2)), 0, 2);
      test_back_to_back();
      test_overflow();
      test_mid_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fir_window_gen.md
# fir_window_gen

Horizontal window generator for the 2-D FIR path. It sits downstream of the line-buffer controller and consumes its vertical tap columns (TAP_NUMS pixels per column, one column per enabled cycle). It assembles them into a TAP_NUMS×TAP_NUMS pixel window centred on each output pixel. Left and right image edges are handled by column replication, so the kernel datapath receives exactly h_size_i windows per line.

## Interface
- DATA_WIDTH, 8, bits per pixel
- TAP_NUMS, 3, kernel size; odd, ≥3. HALF = (TAP_NUMS-1)/2
- LINE_CNT, 12, width of line-length and column counters

- clk  in  1  clock; all logic on its rising edge
- rst_n  in  1  reset, asynchronous, active-low
- col_en_i  in  1  column valid (line-buffer output_en)
- col_data_i  in  TAP_NUMS*DATA_WIDTH  column pixels; packing passed through unchanged
- h_size_i  in  LINE_CNT  pixels per line; legal range HALF+1 .. 2^LINE_CNT-1; sampled on column 0 of each line
- win_en_o  out  1  window valid
- win_data_o  out  TAP_NUMS*TAP_NUMS*DATA_WIDTH  window; column c (0 = leftmost/oldest) at bits [(c+1)*TAP_NUMS*DATA_WIDTH-1 : c*TAP_NUMS*DATA_WIDTH]
- win_first_o  out  1  qualifies the first window of a line
- win_last_o  out  1  qualifies the last window of a line
- busy_o  out  1  high in RUN or FLUSH
- ovf_o  out  1  sticky: a column arrived during FLUSH and was dropped

## Operation
- Storage: TAP_NUMS-column shift register sr[0..TAP_NUMS-1]; sr[TAP_NUMS-1] holds the newest column. Also col_cnt (LINE_CNT bits), h_size_r, flush_cnt.
- Shift operation: sr[c] <= sr[c+1], and sr[TAP_NUMS-1] <= new column.
- Window k (k = 0..W-1, W = h_size_r) holds columns k-HALF .. k+HALF. Indices are clamped to the range 0..W-1.
- IDLE, col_en_i:
  - load every sr slot with col_data_i
  - h_size_r <= h_size_i, col_cnt <= 1
  - go to RUN; no window emitted
- RUN, col_en_i, column j = col_cnt:
  - shift in col_data_i
  - if j ≥ HALF, emit window j-HALF
  - col_cnt <= j+1
  - if j == W-1, go to FLUSH with flush_cnt <= HALF
- RUN without col_en_i: hold all state; no output.
- FLUSH, every cycle, with no input needed:
  - shift in a copy of sr[TAP_NUMS-1] (right-edge replication)
  - emit the next window; flush_cnt decrements
  - the cycle with flush_cnt == 1 emits win_last_o and returns to IDLE with col_cnt <= 0
- col_en_i in FLUSH: the column is dropped, ovf_o <= 1, and the flush sequence is unaffected. Upstream must leave ≥ HALF idle cycles between lines.
- win_first_o accompanies window 0. win_last_o accompanies window W-1. For W = HALF+1 these are distinct windows.
- Total windows per line = W exactly.
- Illegal h_size_i below HALF+1 is not supported; the FSM still runs exactly HALF flush cycles and returns to IDLE (no hang).

## Timing
- Reset values: win_en_o, win_first_o, win_last_o, busy_o, ovf_o = 0; win_data_o = 0; sr, col_cnt, h_size_r, flush_cnt = 0; state IDLE.
- Reset asserted mid-line or mid-flush aborts immediately; after release the next col_en_i is treated as column 0.
- All outputs are registered. A window appears on win_* exactly 1 cycle after the col_en_i cycle (or flush cycle) that completes it.
- win_en_o is a single-cycle pulse per window; win_data_o holds its value when win_en_o is low.
- With back-to-back columns, the output burst is W consecutive win_en_o cycles. It starts 1+HALF cycles after column 0 and continues through the HALF flush cycles.
- busy_o rises the cycle after column 0 is accepted. It falls the cycle after the final flush cycle.
- Back-to-back lines: a column 0 arriving the cycle after the FSM returns to IDLE is accepted normally.

## Test plan
- TAP_NUMS=3, h_size_i=4, columns C0..C3 back-to-back -> 4 windows on consecutive cycles, starting 2 cycles after C0: [C0,C0,C1] (first), [C0,C1,C2], [C1,C2,C3], [C2,C3,C3] (last).
- TAP_NUMS=5, h_size_i=3 (= HALF+1), columns C0..C2 -> 3 windows: [C0,C0,C0,C1,C2] (first), [C0,C0,C1,C2,C2], [C0,C1,C2,C2,C2] (last).
- TAP_NUMS=3, h_size_i=6, col_en_i gapped (one idle cycle between columns) -> same 6 windows as gapless; each win_en_o appears 1 cycle after its completing column; the single flush window follows the cycle after C5.
- Column 0 of line 2 injected during line 1's FLUSH -> that column dropped, ovf_o=1 and stays high; line 1 still emits its last window. Line 2 restarted after IDLE -> correct windows.
- rst_n pulsed low after C2 of a 6-column line -> all outputs 0 asynchronously. A fresh 4-column line then yields exactly 4 windows, win_first_o on the first.
- Two 4-column lines separated by exactly HALF=1 idle cycle -> 8 windows, no ovf_o, win_first_o/win_last_o correct on both lines.
